// File: rtl/cacheline_adaptor_if.sv
// Bundle of the cache-side line interface and the memory-side burst interface.
// The slave modport is the adaptor's view; master is the environment's view.
interface cacheline_adaptor_if;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  modport master (
    output line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_read, burst_write, burst_address, burst_wdata
  );

  modport slave (
    input  line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cacheline reads/writes into 4-beat 64-bit memory bursts.
// Define CACHELINE_ADAPTOR_FAST_RESP_EN to respond in the last-beat cycle and skip DONE.
module cacheline_adaptor (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  localparam state_e RespState = StIdle;
`else
  localparam state_e RespState = StDone;
`endif

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wline_q, wline_d;
  logic [191:0] fill_q, fill_d;   // beats 0..2 of a read in flight
  logic [255:0] rdata_q, rdata_d; // last completed read line
  logic         last_beat;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    fill_d    = fill_q;
    rdata_d   = rdata_q;
    last_beat = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.line_read || bus_io.line_write) begin
          addr_d  = {bus_io.line_address[31:5], 5'b0};
          beat_d  = 2'd0;
          state_d = bus_io.line_read ? StRead : StWrite;
        end
        if (!bus_io.line_read && bus_io.line_write) begin
          wline_d = bus_io.line_wdata;
        end
      end
      StRead: begin
        if (bus_io.burst_resp) begin
          beat_d = beat_q + 2'd1;
          unique case (beat_q)
            2'd0: fill_d[63:0]    = bus_io.burst_rdata;
            2'd1: fill_d[127:64]  = bus_io.burst_rdata;
            2'd2: fill_d[191:128] = bus_io.burst_rdata;
            2'd3: begin
              last_beat = 1'b1;
              rdata_d   = {bus_io.burst_rdata, fill_q};
            end
          endcase
        end
      end
      StWrite: begin
        if (bus_io.burst_resp) begin
          beat_d    = beat_q + 2'd1;
          last_beat = (beat_q == 2'd3);
        end
      end
      StDone: state_d = StIdle;
    endcase

    if (last_beat) begin
      state_d = RespState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      wline_q <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_io.burst_read    = (state_q == StRead);
  assign bus_io.burst_write   = (state_q == StWrite);
  assign bus_io.burst_address = addr_q;
  assign bus_io.burst_wdata   = wline_q[{beat_q, 6'd0} +: 64];

`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  assign bus_io.line_resp  = last_beat;
  // rdata_d carries the live last beat in the completing cycle, rdata_q otherwise.
  assign bus_io.line_rdata = rdata_d;
`else
  assign bus_io.line_resp  = (state_q == StDone);
  assign bus_io.line_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: driver acts as cache and memory, monitor checks bursts
// and line responses against expectations queued when each request is issued.
module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_FAST_RESP_EN
  localparam int RespLat = 3;
`else
  localparam int RespLat = 4;
`endif

  typedef struct {
    bit           is_read;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  exp_t         exp_q[$];
  logic [63:0]  wbeat_q[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           beats_seen = 0;
  int           resp_count = 0;
  int           resp_target = 0;
  int           resp_cyc = 0;
  int           first_beat_cyc = 0;
  bit           in_reset = 1'b1;
  bit           burst_done = 1'b0;
  logic [255:0] model_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!in_reset) begin
      if (burst_done) begin
        check("burst_end", {bus.burst_read, bus.burst_write}, 2'b00);
        burst_done = 1'b0;
      end
      if (bus.burst_read || bus.burst_write) begin
        if (exp_q.size() == 0) begin
          check("spurious_burst", {bus.burst_read, bus.burst_write}, 2'b00);
        end else begin
          check("burst_addr", bus.burst_address, exp_q[0].addr);
          check("burst_kind", {bus.burst_read, bus.burst_write},
                exp_q[0].is_read ? 2'b10 : 2'b01);
          if (bus.burst_write && wbeat_q.size() > 0) begin
            check("burst_wdata", bus.burst_wdata, wbeat_q[0]);
            if (bus.burst_resp) void'(wbeat_q.pop_front());
          end
          if (bus.burst_resp) begin
            beats_seen++;
            if (beats_seen == 4) burst_done = 1'b1;
          end
        end
      end
      if (bus.line_resp) begin
        resp_count++;
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_resp", bus.line_resp, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("resp_after_4_beats", beats_seen, 4);
          beats_seen = 0;
          if (e.is_read) begin
            check("line_rdata", bus.line_rdata, e.line);
            model_rdata = e.line;
          end else begin
            check("rdata_kept_on_write", bus.line_rdata, model_rdata);
          end
        end
      end else begin
        check("rdata_hold", bus.line_rdata, model_rdata);
      end
    end
  end

  // Driver tasks keep the invariant: they start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 read and write together (read must win)
  task automatic issue(input int kind, input logic [31:0] addr, input logic [255:0] line);
    exp_t x;
    x.is_read = (kind != 1);
    x.addr    = {addr[31:5], 5'b0};
    x.line    = line;
    bus.line_address = addr;
    if (kind != 1) bus.line_read = 1'b1;
    if (kind != 0) begin
      bus.line_write = 1'b1;
      bus.line_wdata = (kind == 2) ? ~line : line;
    end
    if (kind == 1) begin
      for (int b = 0; b < 4; b++) wbeat_q.push_back(line[64*b +: 64]);
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_start();
    bit started = 1'b0;
    for (int n = 0; n < 10 && !started; n++) begin
      @(negedge clk);
      started = bus.burst_read | bus.burst_write;
    end
    if (!started) begin
      errors++;
      $display("FAIL burst_start: no burst within 10 cycles, required one");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "burst never started");
    end
    tick();
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
  endtask

  task automatic run_beats(input logic [255:0] line, input int g0, input int g1, input int g2,
                           input int g3, input bit rd, input int nbeats);
    int gaps[4];
    gaps = '{g0, g1, g2, g3};
    for (int b = 0; b < nbeats; b++) begin
      repeat (gaps[b]) begin
        bus.burst_resp  = 1'b0;
        bus.burst_rdata = {$urandom, $urandom};
        tick();
      end
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = rd ? line[64*b +: 64] : {$urandom, $urandom};
      if (b == 0) first_beat_cyc = cyc;
      tick();
    end
    bus.burst_resp = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    resp_target++;
    while (resp_count < resp_target && n < 20) begin
      tick();
      n++;
    end
    if (resp_count < resp_target) begin
      check("line_resp_timeout", resp_count, resp_target);
      resp_count = resp_target;
    end
  endtask

  task automatic txn(input int kind, input logic [31:0] addr, input logic [255:0] line,
                     input int g0, input int g1, input int g2, input int g3);
    issue(kind, addr, line);
    wait_start();
    run_beats(line, g0, g1, g2, g3, kind != 1, 4);
    wait_resp();
  endtask

  task automatic flush_model();
    exp_q.delete();
    wbeat_q.delete();
    beats_seen  = 0;
    burst_done  = 1'b0;
    model_rdata = '0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l1, l2;
    logic [31:0]  a1;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_line_resp", bus.line_resp, 1'b0);
    check("rst_burst_read", bus.burst_read, 1'b0);
    check("rst_burst_write", bus.burst_write, 1'b0);
    check("rst_burst_address", bus.burst_address, 32'h0);
    check("rst_burst_wdata", bus.burst_wdata, 64'h0);
    check("rst_line_rdata", bus.line_rdata, 256'h0);
    @(posedge clk);
    #1;
    in_reset = 1'b0;

    // Unstalled read with known data and latency
    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    issue(0, 32'h0000_1234, l1);
    wait_start();
    check("read_aligned_addr", bus.burst_address, 32'h0000_1220);
    run_beats(l1, 0, 0, 0, 0, 1'b1, 4);
    wait_resp();
    check("read_latency", resp_cyc - first_beat_cyc, RespLat);
    check("read_line_const", bus.line_rdata,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Stalled write
    txn(1, 32'h8000_00ff, rand256(), 0, 2, 0, 2);

    // Simultaneous read and write request
    txn(2, 32'h0bad_cafe, rand256(), 1, 0, 1, 0);

    // Reset after beat 1 of a read, then a normal read
    l1 = rand256();
    issue(0, 32'h1357_9bdf, l1);
    wait_start();
    run_beats(l1, 0, 0, 0, 0, 1'b1, 2);
    rst = 1'b1;
    in_reset = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_burst_read", bus.burst_read, 1'b0);
    check("midrst_line_resp", bus.line_resp, 1'b0);
    check("midrst_line_rdata", bus.line_rdata, 256'h0);
    @(posedge clk);
    #1;
    flush_model();
    in_reset = 1'b0;
    repeat (3) tick();
    txn(0, 32'h2468_ace0, rand256(), 0, 1, 0, 0);

    // Write request held through a read's completion
    l1 = rand256();
    l2 = rand256();
    issue(0, 32'h0000_4444, l1);
    wait_start();
    issue(1, 32'h0000_9999, l2);
    run_beats(l1, 0, 0, 0, 0, 1'b1, 4);
    wait_resp();
    wait_start();
    run_beats(l2, 1, 0, 0, 1, 1'b0, 4);
    wait_resp();

    // Randomized traffic with stray burst_resp pulses while idle
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.burst_resp = 1'($urandom_range(0, 1));
        tick();
      end
      bus.burst_resp = 1'b0;
      a1 = $urandom;
      txn($urandom_range(0, 2), a1, rand256(), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 line_read  input  1  cacheline read request from the cache arbiter.
REQ-005 line_write  input  1  cacheline write request from the cache arbiter.
REQ-006 line_address  input  32  byte address of the line.
REQ-007 line_wdata  input  256  write line.
REQ-008 line_rdata  output  256  read line.
REQ-009 line_resp  output  1  one-cycle completion pulse.
REQ-010 burst_read  output  1  burst read to physical memory.
REQ-011 burst_write  output  1  burst write to physical memory.
REQ-012 burst_address  output  32  32-byte-aligned burst address.
REQ-013 burst_wdata  output  64  current write beat.
REQ-014 burst_rdata  input  64  current read beat.
REQ-015 burst_resp  input  1  beat accepted (write) or valid (read); beats may be separated by idle cycles.

Function
REQ-016 The block SHALL implement states IDLE, READ, WRITE and DONE, with a 2-bit beat counter.
REQ-017 In IDLE with line_read=1, the block SHALL capture {line_address[31:5],5'b0} and enter READ, with beat counter=0.
REQ-018 In IDLE with line_write=1 and line_read=0, the block SHALL capture the aligned address and line_wdata and enter WRITE, with beat counter=0.
REQ-019 When line_read and line_write are both 1 in IDLE, read SHALL win.
REQ-020 burst_read SHALL be 1 throughout READ.
REQ-021 burst_write SHALL be 1 throughout WRITE.
REQ-022 burst_address SHALL hold the captured address, constant for the whole burst.
REQ-023 On each burst_resp in READ, the block SHALL store burst_rdata into line buffer bits [64k+63:64k] (k = beat counter) and increment k.
REQ-024 In WRITE, burst_wdata SHALL equal captured line bits [64k+63:64k]; each burst_resp SHALL increment k.
REQ-025 Cycles with burst_resp=0 SHALL leave k, buffer and outputs unchanged.
REQ-026 burst_resp on beat k=3 SHALL end the burst: burst_read/burst_write deassert the next cycle and k wraps to 0.
REQ-027 A burst, once started, SHALL complete all 4 beats even if line_read/line_write drop.
REQ-028 line_read/line_write SHALL be ignored outside IDLE; no request is queued.
REQ-029 line_resp SHALL pulse for exactly one cycle per burst; DONE SHALL always return to IDLE.
REQ-030 line_rdata SHALL hold the last completed read line until the next read completes.
REQ-031 A write SHALL NOT modify line_rdata.
REQ-032 burst_resp received in IDLE or DONE SHALL be ignored.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL go to IDLE and clear k.
REQ-034 Reset SHALL clear line_resp, burst_read, burst_write, burst_address, burst_wdata and line_rdata to 0.
REQ-035 Reset mid-burst SHALL abandon the burst, with burst_read/burst_write low from the next cycle; no line_resp SHALL be issued for the abandoned burst.

Configuration
REQ-036 With macro CACHELINE_ADAPTOR_FAST_RESP_EN defined, line_resp SHALL assert in the same cycle as the beat-3 burst_resp.
- In that cycle, line_rdata[255:192] SHALL be driven combinationally from burst_rdata.
- DONE is skipped; the block returns directly to IDLE.
- Latency: request-to-resp = beats only.
REQ-037 With CACHELINE_ADAPTOR_FAST_RESP_EN undefined, line_resp SHALL assert in DONE, one cycle after the beat-3 burst_resp.
- line_rdata SHALL be driven purely from registers.

Verification
REQ-038 Read, no stalls: line_read=1, address 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles.
- burst_address=0x0000_1220.
- line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- One line_resp pulse, 5th cycle after the first beat (4th with FAST_RESP).
REQ-039 Write, with stalls: line_write=1, line_wdata={D3,D2,D1,D0}; burst_resp given on cycles 2, 5, 6, 9.
- burst_wdata=D0 until cycle 2, then D1, D2, D3 in turn.
- burst_write drops after cycle 9.
- line_rdata unchanged.
REQ-040 Simultaneous line_read=1 and line_write=1 in IDLE: burst_read=1 and burst_write=0 for the whole burst.
REQ-041 Reset mid-burst: rst=1 after beat 1 of a read.
- Next cycle: burst_read=0, line_resp=0, line_rdata=0.
- A following read completes normally.
REQ-042 Request dropped mid-burst: line_read dropped after beat 0; all 4 beats still complete, line_resp pulses once, then IDLE.
REQ-043 Back-to-back: a write request held high through resp of the preceding read; the write burst starts from IDLE with k=0 and the correct aligned address.
